// File: rtl/mem_pkg.sv
// Shared definitions for the RAM memory-function-complete controller:
// FSM state encoding, default geometry and latencies.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int WORD_W            = 32;
    localparam int RAM_ADDR_W        = 8;
    localparam int DEF_READ_LATENCY  = 2;
    localparam int DEF_WRITE_LATENCY = 1;
    localparam int CNT_W             = 3;

endpackage

// File: rtl/ram_mfc_controller.sv
// Bridges the processor RAM port to a fixed-latency synchronous RAM and
// signals completion with a four-phase request / MFC handshake.
module ram_mfc_controller
    import mem_pkg::*;
#(
    parameter int ADDR_W        = RAM_ADDR_W,
    parameter int READ_LATENCY  = DEF_READ_LATENCY,
    parameter int WRITE_LATENCY = DEF_WRITE_LATENCY
) (
    input  logic              Clock,
    input  logic              Reset_L,
    input  logic              RAM1_Request,
    input  logic              RAM1_Read_H_Write_L,
    input  logic [WORD_W-1:0] RAM1_Address,
    input  logic [WORD_W-1:0] RAM1_Data_In,
    output logic [WORD_W-1:0] RAM1_Data_Out,
    output logic              RAM1_MFC,
    output logic              RAM1_Addr_Error,
    output logic              Busy,
    output logic [ADDR_W-1:0] Ram_Address,
    output logic [WORD_W-1:0] Ram_Data,
    output logic              Ram_WrEn,
    input  logic [WORD_W-1:0] Ram_Q
);

    localparam logic [CNT_W-1:0] RD_LAT = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] WR_LAT = CNT_W'(WRITE_LATENCY);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              op_q,    op_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              wren_q,  wren_d;
    logic              mfc_q,   mfc_d;
    logic              err_q,   err_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    logic              in_range;
    logic [CNT_W-1:0]  lat;

    // Any set bit above the physical width is an error, never an alias.
    assign in_range = (RAM1_Address[WORD_W-1:ADDR_W] == '0);
    assign lat      = op_q ? RD_LAT : WR_LAT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = wren_q;
        mfc_d   = mfc_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (RAM1_Request) begin
                    if (in_range) begin
                        addr_d  = RAM1_Address[ADDR_W-1:0];
                        wdata_d = RAM1_Data_In;
                        wren_d  = ~RAM1_Read_H_Write_L;
                        op_d    = RAM1_Read_H_Write_L;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCESS;
                    end else begin
                        mfc_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            ACCESS: begin
                // Write enable is only ever high for the cycle after acceptance.
                wren_d = 1'b0;
                if (cnt_q == lat) begin
                    mfc_d   = 1'b1;
                    state_d = DONE;
                    if (op_q) begin
                        rdata_d = Ram_Q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (!RAM1_Request) begin
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign RAM1_Data_Out   = rdata_q;
    assign RAM1_MFC        = mfc_q;
    assign RAM1_Addr_Error = err_q;
    assign Busy            = (state_q != IDLE);
    assign Ram_Address     = addr_q;
    assign Ram_Data        = wdata_q;
    assign Ram_WrEn        = wren_q;

endmodule

// File: tb/tb_ram_mfc_controller.sv
// Self-checking bench for ram_mfc_controller: behavioural RAM, shadow memory
// and handshake timing derived from the latency rules.
module tb_ram_mfc_controller;
    import mem_pkg::*;

    localparam int AW = 8;
    localparam int RL = 2;
    localparam int WL = 1;

    logic          Clock = 1'b0;
    logic          Reset_L = 1'b0;
    logic          req = 1'b0;
    logic          rw = 1'b1;
    logic [31:0]   addr = '0;
    logic [31:0]   din = '0;
    logic [31:0]   RAM1_Data_Out;
    logic          RAM1_MFC, RAM1_Addr_Error, Busy;
    logic [AW-1:0] Ram_Address;
    logic [31:0]   Ram_Data;
    logic          Ram_WrEn;
    logic [31:0]   Ram_Q;

    int checks = 0;
    int fails  = 0;
    int wren_total = 0;
    logic [31:0] shadow [0:(1<<AW)-1];
    logic [31:0] exp_dout = '0;

    always #5 Clock = ~Clock;

    ram_mfc_controller #(
        .ADDR_W(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .Clock(Clock), .Reset_L(Reset_L),
        .RAM1_Request(req), .RAM1_Read_H_Write_L(rw),
        .RAM1_Address(addr), .RAM1_Data_In(din),
        .RAM1_Data_Out(RAM1_Data_Out), .RAM1_MFC(RAM1_MFC),
        .RAM1_Addr_Error(RAM1_Addr_Error), .Busy(Busy),
        .Ram_Address(Ram_Address), .Ram_Data(Ram_Data),
        .Ram_WrEn(Ram_WrEn), .Ram_Q(Ram_Q)
    );

    // Behavioural synchronous RAM: data valid RL edges after the address changes.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] q_pipe [0:3];
    logic        ram_init = 1'b0;

    always @(posedge Clock) begin
        if (!ram_init) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
            ram_init <= 1'b1;
        end else if (Ram_WrEn) begin
            mem[Ram_Address] <= Ram_Data;
        end
        q_pipe[0] <= mem[Ram_Address];
        for (int i = 1; i < 4; i++) q_pipe[i] <= q_pipe[i-1];
    end

    generate
        if (RL == 1) begin : g_q_direct
            assign Ram_Q = mem[Ram_Address];
        end else begin : g_q_piped
            assign Ram_Q = q_pipe[RL-2];
        end
    endgenerate

    always @(negedge Clock) if (Ram_WrEn === 1'b1) wren_total++;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Returns the number of edges until MFC is seen, or -1 on timeout.
    task automatic wait_mfc(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (RAM1_MFC === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({RAM1_MFC, RAM1_Addr_Error, Busy, Ram_WrEn, Ram_Address, Ram_Data, RAM1_Data_Out} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got mfc=%b err=%b busy=%b wren=%b addr=%h data=%h dout=%h, required all 0",
                     RAM1_MFC, RAM1_Addr_Error, Busy, Ram_WrEn, Ram_Address, Ram_Data, RAM1_Data_Out);
        end
        tick();
        Reset_L = 1'b1;
        tick();
        checks++;
        if (Busy !== 1'b0 || RAM1_MFC !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got busy=%b mfc=%b, required 0 0", Busy, RAM1_MFC);
        end
        $display("reset: outputs cleared, idle after release");
    endtask

    task automatic test_write();
        int n, w0;
        w0 = wren_total;
        rw = 1'b0; addr = 32'd5; din = 32'hDEADBEEF; req = 1'b1;
        tick();
        checks++;
        if (Ram_WrEn !== 1'b1 || Ram_Address !== 8'd5 || Ram_Data !== 32'hDEADBEEF || RAM1_MFC !== 1'b0 || Busy !== 1'b1) begin
            fails++;
            $display("FAIL write_issue: got wren=%b addr=%h data=%h mfc=%b busy=%b, required 1 05 deadbeef 0 1",
                     Ram_WrEn, Ram_Address, Ram_Data, RAM1_MFC, Busy);
        end
        rw = 1'b1; addr = $urandom(); din = $urandom();
        wait_mfc(8, n);
        checks++;
        if (n !== WL) begin
            fails++;
            $display("FAIL write_latency: got %0d edges, required %0d", n, WL);
        end
        shadow[5] = 32'hDEADBEEF;
        repeat (2) tick();
        checks++;
        if (RAM1_MFC !== 1'b1 || (wren_total - w0) !== 1) begin
            fails++;
            $display("FAIL write_pulse: got mfc=%b wren_cycles=%0d, required 1 1", RAM1_MFC, wren_total - w0);
        end
        req = 1'b0;
        tick();
        checks++;
        if (RAM1_MFC !== 1'b0 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL write_release: got mfc=%b busy=%b, required 0 0", RAM1_MFC, Busy);
        end
        $display("write: addr=05 data=deadbeef mfc after %0d edge(s)", n);
    endtask

    task automatic test_read();
        int n;
        logic [31:0] d9;
        rw = 1'b1; addr = 32'd5; req = 1'b1;
        tick();
        addr = $urandom(); din = $urandom(); rw = 1'b0;
        wait_mfc(8, n);
        checks++;
        if (n !== RL || RAM1_Data_Out !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL read_data: got %0d edges dout=%h, required %0d deadbeef", n, RAM1_Data_Out, RL);
        end
        exp_dout = 32'hDEADBEEF;
        req = 1'b0;
        tick();
        checks++;
        if (RAM1_MFC !== 1'b0 || RAM1_Data_Out !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL read_persist: got mfc=%b dout=%h, required 0 deadbeef", RAM1_MFC, RAM1_Data_Out);
        end
        d9 = $urandom();
        rw = 1'b0; addr = 32'd9; din = d9; req = 1'b1;
        tick();
        wait_mfc(8, n);
        req = 1'b0;
        tick();
        shadow[9] = d9;
        checks++;
        if (n !== WL || RAM1_Data_Out !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL read_persist_write: got %0d edges dout=%h, required %0d deadbeef", n, RAM1_Data_Out, WL);
        end
        $display("read: addr=05 dout=%h, held through later write", RAM1_Data_Out);
    endtask

    task automatic test_out_of_range();
        int w0;
        w0 = wren_total;
        rw = 1'b1; addr = 32'h100; req = 1'b1;
        tick();
        checks++;
        if (RAM1_MFC !== 1'b1 || RAM1_Addr_Error !== 1'b1 || Busy !== 1'b1 || RAM1_Data_Out !== exp_dout) begin
            fails++;
            $display("FAIL oor_flag: got mfc=%b err=%b busy=%b dout=%h, required 1 1 1 %h",
                     RAM1_MFC, RAM1_Addr_Error, Busy, RAM1_Data_Out, exp_dout);
        end
        tick();
        req = 1'b0;
        tick();
        checks++;
        if (RAM1_MFC !== 1'b0 || RAM1_Addr_Error !== 1'b0 || Busy !== 1'b0 || (wren_total - w0) !== 0) begin
            fails++;
            $display("FAIL oor_clear: got mfc=%b err=%b busy=%b wren_cycles=%0d, required 0 0 0 0",
                     RAM1_MFC, RAM1_Addr_Error, Busy, wren_total - w0);
        end
        $display("out_of_range: addr=00000100 flagged, no ram access");
    endtask

    task automatic test_hold();
        int n, w0, low_seen;
        logic [31:0] a, d;
        a = {24'h0, 8'($urandom())}; d = $urandom();
        w0 = wren_total;
        rw = 1'b0; addr = a; din = d; req = 1'b1;
        tick();
        wait_mfc(8, n);
        low_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (RAM1_MFC !== 1'b1) low_seen++;
        end
        shadow[a[7:0]] = d;
        checks++;
        if (n !== WL || low_seen !== 0 || (wren_total - w0) !== 1) begin
            fails++;
            $display("FAIL hold_mfc: got edges=%0d mfc_low_cycles=%0d wren_cycles=%0d, required %0d 0 1",
                     n, low_seen, wren_total - w0, WL);
        end
        req = 1'b0;
        tick();
        checks++;
        if (RAM1_MFC !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: got mfc=%b, required 0", RAM1_MFC);
        end
        rw = 1'b1; req = 1'b1;
        tick();
        checks++;
        if (Busy !== 1'b1) begin
            fails++;
            $display("FAIL rerequest_accept: got busy=%b, required 1", Busy);
        end
        wait_mfc(8, n);
        checks++;
        if (n !== RL || RAM1_Data_Out !== d) begin
            fails++;
            $display("FAIL rerequest_read: got %0d edges dout=%h, required %0d %h", n, RAM1_Data_Out, RL, d);
        end
        exp_dout = d;
        req = 1'b0;
        tick();
        $display("hold: addr=%h single access, rerequest accepted immediately", a[7:0]);
    endtask

    task automatic test_early_drop();
        int n;
        rw = 1'b1; addr = 32'd9; req = 1'b1;
        tick();
        req = 1'b0;
        wait_mfc(8, n);
        checks++;
        if (n !== RL || RAM1_Data_Out !== shadow[9]) begin
            fails++;
            $display("FAIL early_drop_data: got %0d edges dout=%h, required %0d %h", n, RAM1_Data_Out, RL, shadow[9]);
        end
        exp_dout = shadow[9];
        tick();
        checks++;
        if (RAM1_MFC !== 1'b0 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL early_drop_pulse: got mfc=%b busy=%b, required 0 0", RAM1_MFC, Busy);
        end
        $display("early_drop: addr=09 one-cycle mfc, dout=%h", RAM1_Data_Out);
    endtask

    task automatic test_random();
        int n, m, w0, hold, exp_n;
        logic op, oor, early;
        logic [31:0] a, d, exp_d;
        for (int t = 0; t < 40; t++) begin
            op = 1'($urandom()); oor = ($urandom_range(0, 7) == 0);
            d = $urandom(); hold = $urandom_range(0, 3);
            early = !oor && ($urandom_range(0, 3) == 0);
            if (oor) begin
                a = $urandom();
                if (a[31:AW] == '0) a[31] = 1'b1;
            end else begin
                a = {24'h0, 8'($urandom())};
            end
            exp_n = oor ? 1 : 1 + (op ? RL : WL);
            exp_d = (op && !oor) ? shadow[a[7:0]] : exp_dout;
            w0 = wren_total;
            rw = op; addr = a; din = d; req = 1'b1;
            tick();
            rw = 1'($urandom()); addr = $urandom(); din = $urandom();
            if (RAM1_MFC === 1'b1) begin
                n = 1;
            end else begin
                if (early) req = 1'b0;
                wait_mfc(10, m);
                n = (m < 0) ? -1 : m + 1;
            end
            checks++;
            if (n !== exp_n || RAM1_Addr_Error !== oor || RAM1_Data_Out !== exp_d ||
                (wren_total - w0) !== ((!op && !oor) ? 1 : 0)) begin
                fails++;
                $display("FAIL rand_%0d: got edges=%0d err=%b dout=%h wren=%0d, required %0d %b %h %0d",
                         t, n, RAM1_Addr_Error, RAM1_Data_Out, wren_total - w0,
                         exp_n, oor, exp_d, (!op && !oor) ? 1 : 0);
            end
            exp_dout = exp_d;
            if (!op && !oor) shadow[a[7:0]] = d;
            if (!early) begin
                repeat (hold) tick();
                req = 1'b0;
                tick();
            end else begin
                tick();
            end
            checks++;
            if (RAM1_MFC !== 1'b0 || RAM1_Addr_Error !== 1'b0 || Busy !== 1'b0) begin
                fails++;
                $display("FAIL rand_%0d_release: got mfc=%b err=%b busy=%b, required 0 0 0",
                         t, RAM1_MFC, RAM1_Addr_Error, Busy);
            end
            $display("rand %0d: %s addr=%h data=%h oor=%b early=%b edges=%0d dout=%h",
                     t, op ? "rd" : "wr", a, d, oor, early, n, RAM1_Data_Out);
        end
    endtask

    task automatic test_reset_mid();
        rw = 1'b0; addr = 32'h77; din = $urandom(); req = 1'b1;
        tick();
        checks++;
        if (Ram_WrEn !== 1'b1) begin
            fails++;
            $display("FAIL reset_access_pre: got wren=%b, required 1", Ram_WrEn);
        end
        #2 Reset_L = 1'b0; req = 1'b0;
        #1;
        checks++;
        if ({RAM1_MFC, RAM1_Addr_Error, Busy, Ram_WrEn, Ram_Address, Ram_Data, RAM1_Data_Out} !== '0) begin
            fails++;
            $display("FAIL reset_in_access: got mfc=%b err=%b busy=%b wren=%b addr=%h data=%h dout=%h, required all 0",
                     RAM1_MFC, RAM1_Addr_Error, Busy, Ram_WrEn, Ram_Address, Ram_Data, RAM1_Data_Out);
        end
        exp_dout = '0;
        tick();
        Reset_L = 1'b1;
        tick();
        checks++;
        if (Busy !== 1'b0 || RAM1_MFC !== 1'b0) begin
            fails++;
            $display("FAIL reset_access_release: got busy=%b mfc=%b, required 0 0", Busy, RAM1_MFC);
        end
        rw = 1'b1; addr = 32'hFFFF_0000; req = 1'b1;
        tick();
        #2 Reset_L = 1'b0; req = 1'b0;
        #1;
        checks++;
        if ({RAM1_MFC, RAM1_Addr_Error, Busy, Ram_WrEn, RAM1_Data_Out} !== '0) begin
            fails++;
            $display("FAIL reset_in_done: got mfc=%b err=%b busy=%b wren=%b dout=%h, required all 0",
                     RAM1_MFC, RAM1_Addr_Error, Busy, Ram_WrEn, RAM1_Data_Out);
        end
        tick();
        Reset_L = 1'b1;
        repeat (2) tick();
        checks++;
        if (Busy !== 1'b0 || RAM1_MFC !== 1'b0) begin
            fails++;
            $display("FAIL reset_done_release: got busy=%b mfc=%b, required 0 0", Busy, RAM1_MFC);
        end
        $display("reset_mid: asynchronous clear in ACCESS and DONE");
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) shadow[i] = '0;
        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_hold();
        test_early_drop();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
